ucie_config_csr: RTL and testbench

//  Register-mapped configuration/status block for the UCIe controller. Software programmes shadow registers over a

---
 rtl/ucie_config_csr.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ucie_config_csr.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucie_config_csr.sv
// UCIe controller configuration/status CSR block: shadowed config with atomic commit, status readback, perf counters.
// Define UCIE_CFG_ACK_TIMEOUT_EN to abandon a commit handshake after ACK_TIMEOUT cycles without cfg_update_ack.
module ucie_config_csr #(
    parameter int NUM_PROTOCOLS = 4,
    parameter int NUM_PERF_CNT  = 8,
    parameter int CNT_WIDTH     = 16,
    parameter int ADDR_W        = 6,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic [NUM_PROTOCOLS-1:0] cfg_protocol_enable,
    output logic [3:0]               cfg_target_speed,
    output logic [7:0]               cfg_target_width,
    output logic [1:0]               cfg_power_state_req,
    output logic [7:0]               cfg_power_budget,
    output logic [7:0]               cfg_error_threshold,
    output logic                     cfg_update_valid,
    input  logic                     cfg_update_ack,
    input  logic                     sts_link_up,
    input  logic                     sts_pam4_active,
    input  logic                     sts_thermal_throttle,
    input  logic [7:0]               sts_current_speed,
    input  logic [NUM_PERF_CNT-1:0]  perf_event
);
`ifdef UCIE_CFG_ACK_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_APPLY    = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_PROTO  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TARGET = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_POWER  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_ERRTH  = ADDR_W'(5);

    logic [1:0]               state_q, state_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic                     overrun_q, overrun_d;
    logic                     timeout_q, timeout_d;
    logic                     upd_valid_q, upd_valid_d;
    logic [NUM_PROTOCOLS-1:0] proto_sh_q, proto_sh_d, proto_act_q, proto_act_d;
    logic [3:0]               speed_sh_q, speed_sh_d, speed_act_q, speed_act_d;
    logic [7:0]               width_sh_q, width_sh_d, width_act_q, width_act_d;
    logic [1:0]               pstate_sh_q, pstate_sh_d, pstate_act_q, pstate_act_d;
    logic [7:0]               budget_sh_q, budget_sh_d, budget_act_q, budget_act_d;
    logic [7:0]               err_th_q, err_th_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [31:0]              rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_err_q, rsp_err_d;
    logic [CNT_WIDTH-1:0]     cnt_q [NUM_PERF_CNT];
    logic [CNT_WIDTH-1:0]     cnt_d [NUM_PERF_CNT];

    logic        pending, req_fire, wr_fire, commit_req, cnt_clr, flag_clr;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic        unused_wdata;

    assign unused_wdata = ^req_wdata[31:16];
    assign pending      = (state_q != ST_IDLE);
    assign req_ready    = !rsp_valid_q || rsp_ready;
    assign req_fire     = req_valid && req_ready;
    assign wr_fire      = req_fire && req_write;
    assign commit_req   = wr_fire && (req_addr == A_CTRL) && req_wdata[0];
    assign cnt_clr      = wr_fire && (req_addr == A_CTRL) && req_wdata[1];
    assign flag_clr     = wr_fire && (req_addr == A_CTRL) && req_wdata[2];

    // Read mux also decides which addresses are mapped; counters sit in a window starting at word 8.
    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b1;
        case (req_addr)
            A_CTRL:   rd_data = {28'd0, timeout_q, overrun_q, 1'b0, pending};
            A_PROTO:  rd_data = 32'(proto_sh_q);
            A_TARGET: rd_data = {20'd0, width_sh_q, speed_sh_q};
            A_POWER:  rd_data = {16'd0, budget_sh_q, 6'd0, pstate_sh_q};
            A_STATUS: rd_data = {14'd0, sts_thermal_throttle, sts_pam4_active, sts_current_speed,
                                 7'd0, sts_link_up};
            A_ERRTH:  rd_data = {24'd0, err_th_q};
            default: begin
                rd_hit = 1'b0;
                for (int i = 0; i < NUM_PERF_CNT; i++) begin
                    if (req_addr == ADDR_W'(8 + i)) begin
                        rd_hit  = 1'b1;
                        rd_data = 32'(cnt_q[i]);
                    end
                end
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;
        upd_valid_d  = upd_valid_q;
        proto_sh_d   = proto_sh_q;
        speed_sh_d   = speed_sh_q;
        width_sh_d   = width_sh_q;
        pstate_sh_d  = pstate_sh_q;
        budget_sh_d  = budget_sh_q;
        proto_act_d  = proto_act_q;
        speed_act_d  = speed_act_q;
        width_act_d  = width_act_q;
        pstate_act_d = pstate_act_q;
        budget_act_d = budget_act_q;
        err_th_d     = err_th_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        cnt_d        = cnt_q;

        if (req_fire) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = !rd_hit;
            rsp_rdata_d = req_write ? 32'd0 : rd_data;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (wr_fire) begin
            case (req_addr)
                A_PROTO:  proto_sh_d = req_wdata[NUM_PROTOCOLS-1:0];
                A_TARGET: begin
                    speed_sh_d = req_wdata[3:0];
                    width_sh_d = req_wdata[11:4];
                end
                A_POWER: begin
                    pstate_sh_d = req_wdata[1:0];
                    budget_sh_d = req_wdata[15:8];
                end
                A_ERRTH:  err_th_d = req_wdata[7:0];
                default: ;
            endcase
        end

        if (flag_clr) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        // A second COMMIT cannot be queued; it only leaves a sticky overrun behind.
        if (commit_req && pending) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (commit_req) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                proto_act_d  = proto_sh_q;
                speed_act_d  = speed_sh_q;
                width_act_d  = width_sh_q;
                pstate_act_d = pstate_sh_q;
                budget_act_d = budget_sh_q;
                upd_valid_d  = 1'b1;
                timer_d      = '0;
                state_d      = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (cfg_update_ack) begin
                    upd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (TIMEOUT_EN && (timer_q == TMR_W'(ACK_TIMEOUT - 1))) begin
                    upd_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else if (TIMEOUT_EN) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear takes priority over an event arriving in the same cycle.
        for (int i = 0; i < NUM_PERF_CNT; i++) begin
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (perf_event[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            upd_valid_q  <= 1'b0;
            proto_sh_q   <= '0;
            speed_sh_q   <= '0;
            width_sh_q   <= '0;
            pstate_sh_q  <= '0;
            budget_sh_q  <= 8'd100;
            proto_act_q  <= '0;
            speed_act_q  <= '0;
            width_act_q  <= '0;
            pstate_act_q <= '0;
            budget_act_q <= 8'd100;
            err_th_q     <= 8'h10;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            for (int i = 0; i < NUM_PERF_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            upd_valid_q  <= upd_valid_d;
            proto_sh_q   <= proto_sh_d;
            speed_sh_q   <= speed_sh_d;
            width_sh_q   <= width_sh_d;
            pstate_sh_q  <= pstate_sh_d;
            budget_sh_q  <= budget_sh_d;
            proto_act_q  <= proto_act_d;
            speed_act_q  <= speed_act_d;
            width_act_q  <= width_act_d;
            pstate_act_q <= pstate_act_d;
            budget_act_q <= budget_act_d;
            err_th_q     <= err_th_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rsp_valid           = rsp_valid_q;
    assign rsp_rdata           = rsp_rdata_q;
    assign rsp_err             = rsp_err_q;
    assign cfg_protocol_enable = proto_act_q;
    assign cfg_target_speed    = speed_act_q;
    assign cfg_target_width    = width_act_q;
    assign cfg_power_state_req = pstate_act_q;
    assign cfg_power_budget    = budget_act_q;
    assign cfg_error_threshold = err_th_q;
    assign cfg_update_valid    = upd_valid_q;

endmodule

// File: tb/tb_ucie_config_csr.sv
// Testbench for ucie_config_csr: register-map vector table, commit/backpressure/counter/reset sequences,
// and a randomized run against a transaction-level model of the CSR block.
module tb_ucie_config_csr;
    localparam int NP   = 4;
    localparam int NC   = 8;
    localparam int CW   = 16;
    localparam int AW   = 6;
    localparam int TO   = 10;
    localparam int CMAX = (1 << CW) - 1;
`ifdef UCIE_CFG_ACK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0, req_write = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid, rsp_err;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic [NP-1:0] cfg_protocol_enable;
    logic [3:0]    cfg_target_speed;
    logic [7:0]    cfg_target_width, cfg_power_budget, cfg_error_threshold;
    logic [1:0]    cfg_power_state_req;
    logic          cfg_update_valid;
    logic          cfg_update_ack = 1'b0;
    logic          sts_link_up = 1'b1, sts_pam4_active = 1'b1, sts_thermal_throttle = 1'b0;
    logic [7:0]    sts_current_speed = 8'h5A;
    logic [NC-1:0] perf_event = '0;

    always #5 clk = ~clk;

    ucie_config_csr #(
        .NUM_PROTOCOLS(NP), .NUM_PERF_CNT(NC), .CNT_WIDTH(CW), .ADDR_W(AW), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cfg_protocol_enable(cfg_protocol_enable), .cfg_target_speed(cfg_target_speed),
        .cfg_target_width(cfg_target_width), .cfg_power_state_req(cfg_power_state_req),
        .cfg_power_budget(cfg_power_budget), .cfg_error_threshold(cfg_error_threshold),
        .cfg_update_valid(cfg_update_valid), .cfg_update_ack(cfg_update_ack),
        .sts_link_up(sts_link_up), .sts_pam4_active(sts_pam4_active),
        .sts_thermal_throttle(sts_thermal_throttle), .sts_current_speed(sts_current_speed),
        .perf_event(perf_event)
    );

    int passCount = 0;
    int checkCount = 0;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;
    vec_t vecs[21];

    // Reference model state: shadow, active, flags, counters and response register.
    logic [3:0]  mProto, aProto, mSpeed, aSpeed;
    logic [7:0]  mWidth, aWidth, mBudget, aBudget, mErrTh;
    logic [1:0]  mPstate, aPstate;
    bit          mOverrun, mTimeout, mPending, mValid, mApplyNext, mRspValid, mRspErr, mAccepted;
    logic [31:0] mRspData;
    int          mWait;
    int          mCnt[NC];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idleReq();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic driveReq(input logic wr, input logic [5:0] addr, input logic [31:0] data);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
    endtask

    // One access with rsp_ready high: accepted at the next edge, response visible at the following negedge.
    task automatic busAccess(input logic wr, input logic [5:0] addr, input logic [31:0] data,
                             output logic [31:0] rdata, output logic err);
        driveReq(wr, addr, data);
        step();
        checkOutput("rsp_valid_after_accept", 32'(rsp_valid), 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
        idleReq();
    endtask

    task automatic csrRead(input string name, input logic [5:0] addr, input logic [31:0] expected);
        logic [31:0] d;
        logic e;
        busAccess(1'b0, addr, 32'd0, d, e);
        checkOutput(name, d, expected);
        checkOutput({name, "_err"}, 32'(e), 32'd0);
    endtask

    task automatic applyStimulus(input int idx);
        logic [31:0] d;
        logic e;
        busAccess(vecs[idx].wr, vecs[idx].addr, vecs[idx].wdata, d, e);
        checkOutput($sformatf("vec%0d_data", idx), d, vecs[idx].expData);
        checkOutput($sformatf("vec%0d_err", idx), 32'(e), 32'(vecs[idx].expErr));
    endtask

    task automatic modelReset();
        mProto = '0; aProto = '0; mSpeed = '0; aSpeed = '0; mWidth = '0; aWidth = '0;
        mPstate = '0; aPstate = '0; mBudget = 8'd100; aBudget = 8'd100; mErrTh = 8'h10;
        mOverrun = 0; mTimeout = 0; mPending = 0; mValid = 0; mApplyNext = 0;
        mRspValid = 0; mRspErr = 0; mRspData = '0; mWait = 0; mAccepted = 0;
        for (int i = 0; i < NC; i++) mCnt[i] = 0;
    endtask

    function automatic bit modelMapped(input int a);
        return (a <= 5) || (a >= 8 && a < 8 + NC);
    endfunction

    function automatic logic [31:0] modelRead(input int a);
        case (a)
            0: return {28'd0, mTimeout, mOverrun, 1'b0, mPending};
            1: return 32'(mProto);
            2: return {20'd0, mWidth, mSpeed};
            3: return {16'd0, mBudget, 6'd0, mPstate};
            4: return {14'd0, sts_thermal_throttle, sts_pam4_active, sts_current_speed, 7'd0, sts_link_up};
            5: return {24'd0, mErrTh};
            default: return (a >= 8 && a < 8 + NC) ? 32'(mCnt[a - 8]) : 32'd0;
        endcase
    endfunction

    // Advances the model across one clock edge using the inputs currently driven.
    task automatic modelEdge();
        bit acc, commitReq, clr, w1c, toHit, oldPending, oldValid;
        acc = req_valid && (!mRspValid || rsp_ready);
        commitReq = 0; clr = 0; w1c = 0; toHit = 0;
        oldPending = mPending; oldValid = mValid;
        mAccepted = acc;
        if (acc) begin
            mRspValid = 1;
            mRspErr   = !modelMapped(int'(req_addr));
            mRspData  = req_write ? 32'd0 : modelRead(int'(req_addr));
        end else if (rsp_ready) begin
            mRspValid = 0;
        end
        if (mApplyNext) begin
            aProto = mProto; aSpeed = mSpeed; aWidth = mWidth; aPstate = mPstate; aBudget = mBudget;
            mValid = 1; mWait = 0; mApplyNext = 0;
        end else if (oldValid) begin
            if (cfg_update_ack) begin
                mValid = 0; mPending = 0;
            end else begin
                mWait++;
                if (TO_EN && mWait == TO) begin
                    mValid = 0; mPending = 0; toHit = 1;
                end
            end
        end
        if (acc && req_write) begin
            case (int'(req_addr))
                0: begin commitReq = req_wdata[0]; clr = req_wdata[1]; w1c = req_wdata[2]; end
                1: mProto = req_wdata[3:0];
                2: begin mSpeed = req_wdata[3:0]; mWidth = req_wdata[11:4]; end
                3: begin mPstate = req_wdata[1:0]; mBudget = req_wdata[15:8]; end
                5: mErrTh = req_wdata[7:0];
                default: ;
            endcase
        end
        if (w1c) begin mOverrun = 0; mTimeout = 0; end
        if (toHit) mTimeout = 1;
        if (commitReq) begin
            if (oldPending) mOverrun = 1;
            else begin mPending = 1; mApplyNext = 1; end
        end
        for (int i = 0; i < NC; i++) begin
            if (clr) mCnt[i] = 0;
            else if (perf_event[i] && mCnt[i] < CMAX) mCnt[i]++;
        end
    endtask

    initial begin
        int highCycles;
        vecs[0]  = '{1'b0, 6'd0,  32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b0, 6'd1,  32'h0,        32'h0,        1'b0};
        vecs[2]  = '{1'b0, 6'd3,  32'h0,        32'h0000_6400, 1'b0};
        vecs[3]  = '{1'b0, 6'd5,  32'h0,        32'h10,       1'b0};
        vecs[4]  = '{1'b1, 6'd1,  32'hFFFF_FFFF, 32'h0,       1'b0};
        vecs[5]  = '{1'b0, 6'd1,  32'h0,        32'hF,        1'b0};
        vecs[6]  = '{1'b1, 6'd2,  32'hFFFF_F123, 32'h0,       1'b0};
        vecs[7]  = '{1'b0, 6'd2,  32'h0,        32'h123,      1'b0};
        vecs[8]  = '{1'b1, 6'd3,  32'hFFFF_FFFF, 32'h0,       1'b0};
        vecs[9]  = '{1'b0, 6'd3,  32'h0,        32'hFF03,     1'b0};
        vecs[10] = '{1'b1, 6'd4,  32'hFFFF_FFFF, 32'h0,       1'b0};
        vecs[11] = '{1'b0, 6'd4,  32'h0,        32'h0001_5A01, 1'b0};
        vecs[12] = '{1'b0, 6'h3F, 32'h0,        32'h0,        1'b1};
        vecs[13] = '{1'b1, 6'h3F, 32'h1234,     32'h0,        1'b1};
        vecs[14] = '{1'b0, 6'd6,  32'h0,        32'h0,        1'b1};
        vecs[15] = '{1'b0, 6'd7,  32'h0,        32'h0,        1'b1};
        vecs[16] = '{1'b0, 6'd16, 32'h0,        32'h0,        1'b1};
        vecs[17] = '{1'b0, 6'd15, 32'h0,        32'h0,        1'b0};
        vecs[18] = '{1'b1, 6'd5,  32'h1AB,      32'h0,        1'b0};
        vecs[19] = '{1'b0, 6'd5,  32'h0,        32'hAB,       1'b0};
        vecs[20] = '{1'b0, 6'd0,  32'h0,        32'h0,        1'b0};

        #12;
        checkOutput("reset_budget", 32'(cfg_power_budget), 32'd100);
        checkOutput("reset_err_th", 32'(cfg_error_threshold), 32'h10);
        checkOutput("reset_proto", 32'(cfg_protocol_enable), 32'd0);
        checkOutput("reset_upd_valid", 32'(cfg_update_valid), 32'd0);
        checkOutput("reset_rsp", {rsp_rdata[29:0], rsp_valid, rsp_err}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        for (int i = 0; i < 21; i++) applyStimulus(i);
        checkOutput("err_th_output", 32'(cfg_error_threshold), 32'hAB);
        checkOutput("proto_not_committed", 32'(cfg_protocol_enable), 32'd0);

        // Commit handshake with an overrun and a W1C while waiting for ack.
        driveReq(1'b1, 6'd0, 32'd1); step();
        checkOutput("proto_before_apply", 32'(cfg_protocol_enable), 32'd0);
        checkOutput("valid_before_apply", 32'(cfg_update_valid), 32'd0);
        driveReq(1'b0, 6'd0, 32'd0); step();
        checkOutput("pending_in_apply", rsp_rdata, 32'd1);
        checkOutput("proto_after_apply", 32'(cfg_protocol_enable), 32'hF);
        checkOutput("target_after_apply", {24'd0, cfg_target_width[3:0], cfg_target_speed}, 32'h23);
        checkOutput("power_after_apply", 32'({cfg_power_budget, cfg_power_state_req}), 32'h3FF);
        checkOutput("valid_after_apply", 32'(cfg_update_valid), 32'd1);
        driveReq(1'b1, 6'd0, 32'd1); step();
        driveReq(1'b1, 6'd1, 32'd5); step();
        checkOutput("proto_held_while_pending", 32'(cfg_protocol_enable), 32'hF);
        driveReq(1'b0, 6'd0, 32'd0); step();
        checkOutput("ctrl_overrun", rsp_rdata, 32'h5);
        driveReq(1'b1, 6'd0, 32'd4); step();
        driveReq(1'b0, 6'd0, 32'd0); step();
        checkOutput("ctrl_after_w1c", rsp_rdata, 32'h1);
        checkOutput("valid_waiting", 32'(cfg_update_valid), 32'd1);
        idleReq(); cfg_update_ack = 1'b1; step();
        cfg_update_ack = 1'b0;
        checkOutput("valid_after_ack", 32'(cfg_update_valid), 32'd0);
        csrRead("ctrl_idle", 6'd0, 32'd0);
        checkOutput("proto_kept", 32'(cfg_protocol_enable), 32'hF);
        cfg_update_ack = 1'b1; step(); step();
        checkOutput("ack_in_idle_ignored", 32'(cfg_update_valid), 32'd0);
        cfg_update_ack = 1'b0;
        csrRead("ctrl_after_idle_ack", 6'd0, 32'd0);

        // Response backpressure on an unmapped read with a second request waiting.
        step();
        rsp_ready = 1'b0;
        driveReq(1'b0, 6'h3F, 32'd0); step();
        driveReq(1'b0, 6'd1, 32'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("bp_req_ready_%0d", k), 32'(req_ready), 32'd0);
            checkOutput($sformatf("bp_rsp_%0d", k), {rsp_rdata[29:0], rsp_valid, rsp_err}, 32'h3);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_req_ready_release", 32'(req_ready), 32'd1);
        step();
        checkOutput("bp_second_rsp", {rsp_rdata[29:0], rsp_valid, rsp_err}, 32'h16);
        idleReq(); step();
        checkOutput("bp_rsp_dropped", 32'(rsp_valid), 32'd0);

        // Counter saturation and clear-beats-event.
        perf_event = 8'h03;
        repeat (3) step();
        perf_event = 8'h01;
        repeat (70000) step();
        csrRead("cnt0_saturated", 6'd8, 32'hFFFF);
        csrRead("cnt1_three", 6'd9, 32'd3);
        driveReq(1'b1, 6'd0, 32'd2); step();
        perf_event = 8'h00;
        idleReq();
        csrRead("cnt0_cleared", 6'd8, 32'd0);
        csrRead("cnt1_cleared", 6'd9, 32'd0);

`ifdef UCIE_CFG_ACK_TIMEOUT_EN
        driveReq(1'b1, 6'd0, 32'd1); step();
        idleReq(); step();
        highCycles = 0;
        for (int k = 0; k < 40 && cfg_update_valid; k++) begin
            highCycles++;
            step();
        end
        checkOutput("timeout_valid_cycles", 32'(highCycles), 32'(TO));
        csrRead("ctrl_timeout", 6'd0, 32'h8);
        driveReq(1'b1, 6'd0, 32'd4); step();
        idleReq();
        csrRead("ctrl_timeout_cleared", 6'd0, 32'd0);
`endif

        // Reset asserted while waiting for ack.
        driveReq(1'b1, 6'd3, 32'h0000_3302); step();
        driveReq(1'b1, 6'd0, 32'd1); step();
        idleReq(); perf_event = '1; step(); step();
        checkOutput("valid_before_reset", 32'(cfg_update_valid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        checkOutput("valid_dropped_by_reset", 32'(cfg_update_valid), 32'd0);
        checkOutput("budget_after_reset", 32'(cfg_power_budget), 32'd100);
        checkOutput("proto_after_reset", 32'(cfg_protocol_enable), 32'd0);
        perf_event = '0;
        @(negedge clk);
        resetn = 1'b1;
        step();
        for (int i = 0; i < NC; i++) csrRead($sformatf("cnt%0d_after_reset", i), 6'(8 + i), 32'd0);
        step();

        // Randomized traffic against the model.
        modelReset();
        for (int c = 0; c < 3000; c++) begin
            if (!(req_valid && !mAccepted)) begin
                if ($urandom_range(0, 2) == 0) idleReq();
                else begin
                    int r;
                    r = $urandom_range(0, 15);
                    driveReq(1'($urandom_range(0, 1)), 6'd0, $urandom);
                    if (r < 3) begin
                        req_write = 1'b1;
                        req_wdata = 32'($urandom_range(0, 7)) & (($urandom_range(0, 3) == 0) ? 32'd7 : 32'd5);
                    end else if (r < 9) req_addr = 6'($urandom_range(1, 5));
                    else if (r < 13) req_addr = 6'(8 + $urandom_range(0, NC - 1));
                    else req_addr = 6'($urandom_range(0, 63));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cfg_update_ack = ($urandom_range(0, 5) == 0);
            perf_event = NC'($urandom & $urandom);
            sts_link_up = 1'($urandom); sts_pam4_active = 1'($urandom);
            sts_thermal_throttle = 1'($urandom); sts_current_speed = 8'($urandom);
            #1;
            checkOutput("rnd_req_ready", 32'(req_ready), 32'(!mRspValid || rsp_ready));
            modelEdge();
            step();
            checkOutput("rnd_rsp_valid", 32'(rsp_valid), 32'(mRspValid));
            checkOutput("rnd_rsp_rdata", rsp_rdata, mRspData);
            checkOutput("rnd_rsp_err", 32'(rsp_err), 32'(mRspErr));
            checkOutput("rnd_cfg", 32'({cfg_protocol_enable, cfg_target_speed, cfg_target_width,
                                        cfg_power_state_req, cfg_power_budget}),
                        32'({aProto, aSpeed, aWidth, aPstate, aBudget}));
            checkOutput("rnd_upd_valid", 32'(cfg_update_valid), 32'(mValid));
            checkOutput("rnd_err_th", 32'(cfg_error_threshold), 32'(mErrTh));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
